// File: rtl/prog_freq_gen_if.sv
// ---------------------------------------------------------------------------
// prog_freq_gen_if
//
// Purpose: bundles the control inputs and measurement outputs of the
// programmable square/PWM generator so the generator and its driver share one
// port object.  Clock and reset are not part of the bundle.
//
// Signals:
//   i_Enable        level; rising edge starts a run, low requests a stop
//   i_Load          one-cycle strobe capturing i_Period / i_High
//   i_Period        period in clocks (CNT_W bits)
//   i_High          high time in clocks (CNT_W bits)
//   i_Burst_Count   periods per run, 0 = continuous (BURST_W bits)
//   o_Freq_Out      generated waveform
//   o_Period_Tick   one-cycle pulse on the first cycle of every period
//   o_Busy          high while running or finishing a graceful stop
//   o_Done          one-cycle pulse when a burst or graceful stop completes
//   o_Load_Pending  shadow values captured but not yet active
//   o_Freq_Out_N    dead-time complementary output (FREQ_GEN_COMPLEMENT_EN)
//
// Modports: master drives the inputs (stimulus / host side), slave is the
// generator itself.
// Optional macro: FREQ_GEN_COMPLEMENT_EN adds o_Freq_Out_N.
// ---------------------------------------------------------------------------
interface prog_freq_gen_if #(
  parameter int CNT_W   = 24,
  parameter int BURST_W = 16
);

  logic               i_Enable;
  logic               i_Load;
  logic [CNT_W-1:0]   i_Period;
  logic [CNT_W-1:0]   i_High;
  logic [BURST_W-1:0] i_Burst_Count;
  logic               o_Freq_Out;
  logic               o_Period_Tick;
  logic               o_Busy;
  logic               o_Done;
  logic               o_Load_Pending;
`ifdef FREQ_GEN_COMPLEMENT_EN
  logic               o_Freq_Out_N;

  modport master (
    output i_Enable, i_Load, i_Period, i_High, i_Burst_Count,
    input  o_Freq_Out, o_Period_Tick, o_Busy, o_Done, o_Load_Pending,
           o_Freq_Out_N
  );

  modport slave (
    input  i_Enable, i_Load, i_Period, i_High, i_Burst_Count,
    output o_Freq_Out, o_Period_Tick, o_Busy, o_Done, o_Load_Pending,
           o_Freq_Out_N
  );
`else
  modport master (
    output i_Enable, i_Load, i_Period, i_High, i_Burst_Count,
    input  o_Freq_Out, o_Period_Tick, o_Busy, o_Done, o_Load_Pending
  );

  modport slave (
    input  i_Enable, i_Load, i_Period, i_High, i_Burst_Count,
    output o_Freq_Out, o_Period_Tick, o_Busy, o_Done, o_Load_Pending
  );
`endif

endinterface

// File: rtl/prog_freq_gen.sv
// ---------------------------------------------------------------------------
// prog_freq_gen
//
// Purpose: programmable square/PWM generator.  Period and high time are
// runtime-loadable in system-clock cycles; runs continuously or for N periods
// (burst), supports a graceful stop, and applies reloads only at period
// boundaries so the waveform never glitches.
//
// Ports:
//   i_Clk    system clock
//   i_Reset  asynchronous, active-high reset
//   bus      prog_freq_gen_if.slave: enable/load/period/high/burst inputs and
//            freq/tick/busy/done/load-pending outputs
//
// Optional macro: FREQ_GEN_COMPLEMENT_EN adds the dead-time complementary
// output o_Freq_Out_N and the DEAD_CLKS parameter.
//
// All outputs are flops (or decoded directly from the state flop), so there
// is no combinational path from any input to any output.
// ---------------------------------------------------------------------------
module prog_freq_gen #(
  parameter int CNT_W      = 24,
  parameter int BURST_W    = 16,
  parameter int DEF_PERIOD = 25000,
  parameter int DEF_HIGH   = 12500
`ifdef FREQ_GEN_COMPLEMENT_EN
  , parameter int DEAD_CLKS = 2
`endif
) (
  input  logic           i_Clk,
  input  logic           i_Reset,
  prog_freq_gen_if.slave bus
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_RUN      = 2'd1;
  localparam logic [1:0] ST_STOPPING = 2'd2;
  localparam logic [1:0] ST_DONE     = 2'd3;

  localparam logic [CNT_W-1:0] DEF_P   = CNT_W'(DEF_PERIOD);
  localparam logic [CNT_W-1:0] DEF_H   = CNT_W'(DEF_HIGH);
  localparam logic [CNT_W-1:0] MIN_P   = CNT_W'(2);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]         state_q,    state_d;
  logic [CNT_W-1:0]   cnt_q,      cnt_d;
  logic [CNT_W-1:0]   per_q,      per_d;
  logic [CNT_W-1:0]   high_q,     high_d;
  logic [CNT_W-1:0]   shd_per_q,  shd_per_d;
  logic [CNT_W-1:0]   shd_high_q, shd_high_d;
  logic               pend_q,     pend_d;
  logic               en_q,       en_d;
  logic [BURST_W-1:0] burst_lim_q, burst_lim_d;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
  logic               freq_q,     freq_d;
  logic               tick_q,     tick_d;
  logic               done_q,     done_d;
`ifdef FREQ_GEN_COMPLEMENT_EN
  logic               comp_q,     comp_d;
`endif

  logic [CNT_W-1:0]   load_per;
  logic [BURST_W-1:0] burst_next;
  logic               busy;
  logic               busy_d;
  logic               wrap;
  logic               burst_hit;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    per_d       = per_q;
    high_d      = high_q;
    shd_per_d   = shd_per_q;
    shd_high_d  = shd_high_q;
    pend_d      = pend_q;
    en_d        = bus.i_Enable;
    burst_lim_d = burst_lim_q;
    burst_cnt_d = burst_cnt_q;
    done_d      = 1'b0;

    // Periods shorter than 2 clocks cannot show both levels, so clamp.
    // H=0 and H>=P need no clamp: cnt<H is then never / always true.
    load_per   = (bus.i_Period < MIN_P) ? MIN_P : bus.i_Period;
    busy       = (state_q == ST_RUN) || (state_q == ST_STOPPING);
    wrap       = busy && (cnt_q == (per_q - CNT_ONE));
    burst_next = burst_cnt_q + BURST_W'(1);
    burst_hit  = wrap && (burst_lim_q != '0) && (burst_next == burst_lim_q);

    // While idle a load takes effect straight away; while running it waits
    // in the shadow so the current period is never cut short or stretched.
    if (bus.i_Load) begin
      if (busy) begin
        shd_per_d  = load_per;
        shd_high_d = bus.i_High;
        pend_d     = 1'b1;
      end else begin
        per_d  = load_per;
        high_d = bus.i_High;
      end
    end

    // The transfer uses the shadow as it stood before this edge, so a load
    // arriving on the wrap cycle itself stays pending for the next wrap.
    if (wrap && pend_q) begin
      per_d  = shd_per_q;
      high_d = shd_high_q;
      pend_d = bus.i_Load;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.i_Enable && !en_q) begin
          state_d     = ST_RUN;
          cnt_d       = '0;
          burst_cnt_d = '0;
          burst_lim_d = bus.i_Burst_Count;
        end
      end

      ST_RUN, ST_STOPPING: begin
        if (wrap) begin
          cnt_d       = '0;
          burst_cnt_d = burst_next;
          // A completed burst outranks a pending stop; both end in one pulse.
          if (burst_hit) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else if (!bus.i_Enable) begin
            if (state_q == ST_STOPPING) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_STOPPING;
            end
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
          state_d = bus.i_Enable ? ST_RUN : ST_STOPPING;
        end
      end

      ST_DONE: begin
        if (!bus.i_Enable) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Waveform flops are computed from next-cycle count and active values so
    // they line up with cnt, including the first cycle after a reload.
    busy_d = (state_d == ST_RUN) || (state_d == ST_STOPPING);
    freq_d = busy_d && (cnt_d < high_d);
    tick_d = busy_d && (cnt_d == '0);
`ifdef FREQ_GEN_COMPLEMENT_EN
    // One extra bit of headroom so H+DEAD and cnt+DEAD cannot overflow and
    // P-DEAD never underflows; an empty window simply never matches.
    comp_d = busy_d
          && (({1'b0, high_d} + (CNT_W+1)'(DEAD_CLKS)) <= {1'b0, cnt_d})
          && (({1'b0, cnt_d}  + (CNT_W+1)'(DEAD_CLKS)) <  {1'b0, per_d});
`endif
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      per_q       <= DEF_P;
      high_q      <= DEF_H;
      shd_per_q   <= DEF_P;
      shd_high_q  <= DEF_H;
      pend_q      <= 1'b0;
      en_q        <= 1'b0;
      burst_lim_q <= '0;
      burst_cnt_q <= '0;
      freq_q      <= 1'b0;
      tick_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef FREQ_GEN_COMPLEMENT_EN
      comp_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      per_q       <= per_d;
      high_q      <= high_d;
      shd_per_q   <= shd_per_d;
      shd_high_q  <= shd_high_d;
      pend_q      <= pend_d;
      en_q        <= en_d;
      burst_lim_q <= burst_lim_d;
      burst_cnt_q <= burst_cnt_d;
      freq_q      <= freq_d;
      tick_q      <= tick_d;
      done_q      <= done_d;
`ifdef FREQ_GEN_COMPLEMENT_EN
      comp_q      <= comp_d;
`endif
    end
  end

  assign bus.o_Freq_Out     = freq_q;
  assign bus.o_Period_Tick  = tick_q;
  assign bus.o_Busy         = busy;
  assign bus.o_Done         = done_q;
  assign bus.o_Load_Pending = pend_q;
`ifdef FREQ_GEN_COMPLEMENT_EN
  assign bus.o_Freq_Out_N   = comp_q;
`endif

endmodule

// File: tb/tb_prog_freq_gen.sv
// ---------------------------------------------------------------------------
// tb_prog_freq_gen
//
// Directed bench for prog_freq_gen.  Each scenario pushes the expected
// {freq, tick, busy, done, load_pending} vector for every upcoming cycle onto
// a queue; the vector is derived from the scenario's own period/high values,
// then popped and compared one clock later.
// Optional macro: FREQ_GEN_COMPLEMENT_EN also checks o_Freq_Out_N.
// ---------------------------------------------------------------------------
module tb_prog_freq_gen;

  localparam int CNT_W   = 24;
  localparam int BURST_W = 16;

  logic i_Clk = 1'b0;
  logic i_Reset;

  prog_freq_gen_if #(.CNT_W(CNT_W), .BURST_W(BURST_W)) bus ();

  prog_freq_gen #(
    .CNT_W(CNT_W),
    .BURST_W(BURST_W),
    .DEF_PERIOD(25000),
    .DEF_HIGH(12500)
  ) dut (
    .i_Clk(i_Clk),
    .i_Reset(i_Reset),
    .bus(bus)
  );

  always #5 i_Clk = ~i_Clk;

  typedef struct {
    string      tag;
    int         idx;
    logic [4:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  task automatic applyStimulus(input logic en, input logic ld, input int per,
                               input int hi, input int burst);
    bus.i_Enable      = en;
    bus.i_Load        = ld;
    bus.i_Period      = CNT_W'(per);
    bus.i_High        = CNT_W'(hi);
    bus.i_Burst_Count = BURST_W'(burst);
  endtask

  task automatic pushExp(input string tag, input int idx, input logic f,
                         input logic t, input logic b, input logic d,
                         input logic p);
    exp_t e;
    e.tag = tag;
    e.idx = idx;
    e.exp = {f, t, b, d, p};
    exp_q.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t       e;
    logic [4:0] obs;
    obs = {bus.o_Freq_Out, bus.o_Period_Tick, bus.o_Busy, bus.o_Done,
           bus.o_Load_Pending};
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("[TB] FAIL scoreboard_empty observed=%b required=none", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.exp) n_pass++;
      else begin
        n_fail++;
        $error("[TB] FAIL %s[%0d] observed=%b expected=%b (freq,tick,busy,done,pend)",
               e.tag, e.idx, obs, e.exp);
      end
    end
  endtask

  task automatic stepCheck();
    @(posedge i_Clk);
    #1;
    checkOutput();
  endtask

  task automatic idleCheck(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      pushExp(tag, i, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      stepCheck();
    end
  endtask

`ifdef FREQ_GEN_COMPLEMENT_EN
  task automatic checkComp(input int idx, input logic expv);
    n_checks++;
    assert (bus.o_Freq_Out_N === expv) n_pass++;
    else begin
      n_fail++;
      $error("[TB] FAIL comp[%0d] observed=%b expected=%b", idx, bus.o_Freq_Out_N, expv);
    end
  endtask
`endif

  initial begin
    int c;

    // Reset state.
    i_Reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 0, 0, 0);
    repeat (3) @(posedge i_Clk);
    #1;
    pushExp("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput();
    i_Reset = 1'b0;
    idleCheck("idle_after_reset", 2);

    // Defaults, shadow load of 1000/250 at cnt=100, then graceful stop.
    $display("[TB] defaults with mid-period reload");
    applyStimulus(1'b1, 1'b0, 0, 0, 0);
    for (int k = 0; k <= 27001; k++) begin
      if (k < 25000) begin
        c = k;
        pushExp("dflt_load", k, c < 12500, c == 0, 1'b1, 1'b0,
                (k >= 101) && (k <= 24999));
      end else if (k < 27000) begin
        c = (k - 25000) % 1000;
        pushExp("dflt_load", k, c < 250, c == 0, 1'b1, 1'b0, 1'b0);
      end else if (k == 27000) begin
        pushExp("dflt_load", k, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      end else begin
        pushExp("dflt_load", k, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      stepCheck();
      if (k == 100)        applyStimulus(1'b1, 1'b1, 1000, 250, 0);
      else if (k == 101)   applyStimulus(1'b1, 1'b0, 1000, 250, 0);
      else if (k == 26000) applyStimulus(1'b0, 1'b0, 0, 0, 0);
    end

    // Burst of 3 periods, P=10 H=3, twice (restart needs a fresh edge).
    $display("[TB] burst");
    applyStimulus(1'b0, 1'b1, 10, 3, 3);
    idleCheck("idle_load", 1);
    for (int run = 0; run < 2; run++) begin
      applyStimulus(1'b1, 1'b0, 10, 3, 3);
      for (int k = 0; k <= 35; k++) begin
        c = k % 10;
        if (k < 30)       pushExp("burst", k, c < 3, c == 0, 1'b1, 1'b0, 1'b0);
        else if (k == 30) pushExp("burst", k, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        else              pushExp("burst", k, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        stepCheck();
      end
      applyStimulus(1'b0, 1'b0, 10, 3, 3);
      idleCheck("burst_idle", 2);
    end

    // Clamp: P=1,H=0 -> period 2 low; wrap-cycle load of P=5,H=9 lands one
    // period late; two loads back to back, the last (4/2) wins.
    $display("[TB] clamps and shadow loads");
    applyStimulus(1'b0, 1'b1, 1, 0, 0);
    idleCheck("clamp_idle_load", 1);
    applyStimulus(1'b1, 1'b0, 0, 0, 0);
    for (int k = 0; k < 20; k++) begin
      logic f;
      if (k < 6) begin
        c = k % 2;  f = 1'b0;
      end else if (k < 11) begin
        c = k - 6;  f = 1'b1;
      end else begin
        c = (k - 11) % 4;  f = (c < 2);
      end
      pushExp("clamp", k, f, c == 0, 1'b1, 1'b0,
              (k == 4) || (k == 5) || (k >= 8 && k <= 10));
      stepCheck();
      if (k == 3)      applyStimulus(1'b1, 1'b1, 5, 9, 0);
      else if (k == 4) applyStimulus(1'b1, 1'b0, 5, 9, 0);
      else if (k == 7) applyStimulus(1'b1, 1'b1, 3, 1, 0);
      else if (k == 8) applyStimulus(1'b1, 1'b1, 4, 2, 0);
      else if (k == 9) applyStimulus(1'b1, 1'b0, 4, 2, 0);
    end
    i_Reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 0, 0, 0);
    #1;
    pushExp("clamp_reset", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput();
    @(posedge i_Clk);
    #1;
    i_Reset = 1'b0;

    // Stop requested at cnt=4 and withdrawn at cnt=7, later a real stop.
    $display("[TB] graceful stop");
    applyStimulus(1'b0, 1'b1, 10, 5, 0);
    idleCheck("stop_idle_load", 1);
    applyStimulus(1'b1, 1'b0, 10, 5, 0);
    for (int k = 0; k <= 41; k++) begin
      c = k % 10;
      if (k < 40)       pushExp("stop", k, c < 5, c == 0, 1'b1, 1'b0, 1'b0);
      else if (k == 40) pushExp("stop", k, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      else              pushExp("stop", k, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      stepCheck();
      if (k == 4)       applyStimulus(1'b0, 1'b0, 10, 5, 0);
      else if (k == 7)  applyStimulus(1'b1, 1'b0, 10, 5, 0);
      else if (k == 34) applyStimulus(1'b0, 1'b0, 10, 5, 0);
    end

    // Async reset at cnt=6 of P=10 H=8, then defaults must be back.
    $display("[TB] mid-period reset");
    applyStimulus(1'b0, 1'b1, 10, 8, 0);
    idleCheck("rst_idle_load", 1);
    applyStimulus(1'b1, 1'b0, 10, 8, 0);
    for (int k = 0; k <= 6; k++) begin
      pushExp("pre_reset", k, 1'b1, k == 0, 1'b1, 1'b0, 1'b0);
      stepCheck();
    end
    i_Reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 0, 0, 0);
    #1;
    pushExp("reset_async", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput();
    pushExp("reset_held", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    stepCheck();
    i_Reset = 1'b0;
    idleCheck("post_reset_idle", 1);
    applyStimulus(1'b1, 1'b0, 0, 0, 0);
    for (int k = 0; k <= 25000; k++) begin
      c = k % 25000;
      pushExp("post_reset_dflt", k, c < 12500, c == 0, 1'b1, 1'b0, 1'b0);
      stepCheck();
    end

`ifdef FREQ_GEN_COMPLEMENT_EN
    // Complement window for P=20 H=8 with 2 dead clocks: cnt 10..17.
    $display("[TB] complementary output");
    i_Reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 0, 0, 0);
    #1;
    checkComp(-1, 1'b0);
    @(posedge i_Clk);
    #1;
    i_Reset = 1'b0;
    applyStimulus(1'b0, 1'b1, 20, 8, 0);
    idleCheck("comp_idle_load", 1);
    checkComp(-2, 1'b0);
    applyStimulus(1'b1, 1'b0, 20, 8, 0);
    for (int k = 0; k < 40; k++) begin
      c = k % 20;
      pushExp("comp_main", k, c < 8, c == 0, 1'b1, 1'b0, 1'b0);
      stepCheck();
      checkComp(k, (c >= 10) && (c < 18));
    end
`endif

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $error("[TB] FAIL scoreboard_leftover observed=%0d required=0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
